// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM state encodings
// and the hard-wired zero register specifier.
package hazard_pkg;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_IWAIT = 2'd1,
        S_DWAIT = 2'd2,
        S_IDROP = 2'd3
    } state_t;

    // Register 0 is hard-wired to zero, so a load targeting it never creates a hazard.
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the EX-stage load destination and the ID-stage sources.
module hazard_detect
    import hazard_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rt,
    output logic             load_use
);

    // Hazard when the load's destination feeds an operand the ID instruction actually reads.
    always_comb begin
        load_use = ex_memread
                 && (ex_rt != REG_W'(REG_ZERO))
                 && ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall sequencer for the 5-stage integer pipeline.
// Control outputs are Mealy (decoded from the registered state and current
// inputs) and are forced low while rst is asserted.
// Optional macro HAZARD_PERF_EN adds stall and flush performance counters.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_RUN   | normal issue
// S_IWAIT | fetch not ready, IF/ID being flushed until the word arrives
// S_DWAIT | data memory busy, whole back end frozen
// S_IDROP | redirect taken while a stale fetch is in flight; discard it
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W        = 5,
    parameter int CNT_W        = 8,
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             idex_hold,
    output logic             exmem_hold,
    output logic             memwb_bubble,
    output logic [1:0]       state,
    output logic             timeout_err
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]      perf_stall_cnt,
    output logic [31:0]      perf_flush_cnt
`endif
);

    state_t             state_q;
    state_t             state_n;
    logic               drop_q;
    logic               drop_n;
    logic [CNT_W-1:0]   wait_cnt;
    logic [CNT_W-1:0]   wait_cnt_n;
    logic               timeout_q;
    logic               timeout_n;

    logic               load_use;

    // Rules 2-5 of the normal issue decode, shared by S_RUN/S_IWAIT and the data-wait release.
    logic               r_pc;
    logic               r_stall;
    logic               r_flush;
    logic               r_bubble;
    logic               r_drop_set;
    state_t             r_next;

    // Final decoded controls before reset gating.
    logic               freeze;
    logic               pc_w;
    logic               stall_w;
    logic               flush_w;
    logic               bubble_w;

    hazard_detect #(
        .REG_W(REG_W)
    ) u_detect (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .ex_memread (ex_memread),
        .ex_rt      (ex_rt),
        .load_use   (load_use)
    );

    // Normal issue priority: redirect, then load-use stall, then fetch wait, then advance.
    always_comb begin
        r_pc       = 1'b0;
        r_stall    = 1'b0;
        r_flush    = 1'b0;
        r_bubble   = 1'b0;
        r_drop_set = 1'b0;
        r_next     = S_RUN;
        if (ex_branch_taken) begin
            r_pc     = 1'b1;
            r_flush  = 1'b1;
            r_bubble = 1'b1;
            if (!imem_ready) begin
                r_next     = S_IDROP;
                r_drop_set = 1'b1;
            end
        end else if (load_use) begin
            r_stall  = 1'b1;
            r_bubble = 1'b1;
            // Leaving a data wait, the stall cycle resumes normal issue.
            r_next   = (state_q == S_DWAIT) ? S_RUN : state_q;
        end else if (!imem_ready) begin
            r_flush = 1'b1;
            r_next  = S_IWAIT;
        end else begin
            r_pc = 1'b1;
        end
    end

    // Per-state decode of controls and next-state values.
    always_comb begin
        freeze     = 1'b0;
        pc_w       = 1'b0;
        stall_w    = 1'b0;
        flush_w    = 1'b0;
        bubble_w   = 1'b0;
        state_n    = state_q;
        drop_n     = drop_q;
        wait_cnt_n = wait_cnt;
        timeout_n  = timeout_q;
        case (state_q)
            S_RUN, S_IWAIT: begin
                if (dmem_req && !dmem_ready) begin
                    freeze     = 1'b1;
                    wait_cnt_n = CNT_W'(1);
                    state_n    = S_DWAIT;
                end else begin
                    pc_w     = r_pc;
                    stall_w  = r_stall;
                    flush_w  = r_flush;
                    bubble_w = r_bubble;
                    state_n  = r_next;
                    if (r_drop_set) drop_n = 1'b1;
                end
            end
            S_DWAIT: begin
                if (wait_cnt == CNT_W'(WAIT_TIMEOUT)) timeout_n = 1'b1;
                if (!dmem_ready) begin
                    freeze = 1'b1;
                    if (wait_cnt != {CNT_W{1'b1}}) wait_cnt_n = wait_cnt + CNT_W'(1);
                end else begin
                    wait_cnt_n = '0;
                    if (drop_q) begin
                        // Redirect happened before the freeze; the stale fetch is still owed.
                        flush_w = 1'b1;
                        if (imem_ready) begin
                            drop_n  = 1'b0;
                            state_n = S_RUN;
                        end else begin
                            state_n = S_IDROP;
                        end
                    end else begin
                        pc_w     = r_pc;
                        stall_w  = r_stall;
                        flush_w  = r_flush;
                        bubble_w = r_bubble;
                        state_n  = r_next;
                        if (r_drop_set) drop_n = 1'b1;
                    end
                end
            end
            S_IDROP: begin
                if (dmem_req && !dmem_ready) begin
                    freeze     = 1'b1;
                    wait_cnt_n = CNT_W'(1);
                    state_n    = S_DWAIT;
                end else begin
                    flush_w = 1'b1;
                    if (imem_ready) begin
                        drop_n  = 1'b0;
                        state_n = S_RUN;
                    end
                end
            end
            default: state_n = S_RUN;
        endcase
    end

    // Outputs are held low while reset is asserted.
    always_comb begin
        pc_write     = rst & pc_w;
        ifid_stall   = rst & (stall_w | freeze);
        ifid_flush   = rst & flush_w;
        idex_bubble  = rst & bubble_w;
        idex_hold    = rst & freeze;
        exmem_hold   = rst & freeze;
        memwb_bubble = rst & freeze;
        state        = state_q;
        timeout_err  = timeout_q;
    end

    // Sequencer state, pending-drop flag, data-wait counter and sticky timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_RUN;
            drop_q    <= 1'b0;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            drop_q    <= drop_n;
            wait_cnt  <= wait_cnt_n;
            timeout_q <= timeout_n;
        end
    end

`ifdef HAZARD_PERF_EN
    // Free-running wrap-around counts of PC-stalled cycles and IF/ID flush cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (!pc_w)   perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (flush_w) perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a driver applies directed and random
// stimulus, a reference model pushes the expected per-cycle controls into a
// queue, and a monitor on the falling edge pops and compares.
module tb_hazard_ctrl;

    localparam int REG_W   = 5;
    localparam int CNT_W   = 8;
    localparam int TO      = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [REG_W-1:0] id_rs = '0;
    logic [REG_W-1:0] id_rt = '0;
    logic             id_uses_rt = 1'b0;
    logic             ex_memread = 1'b0;
    logic [REG_W-1:0] ex_rt = '0;
    logic             ex_branch_taken = 1'b0;
    logic             imem_ready = 1'b1;
    logic             dmem_req = 1'b0;
    logic             dmem_ready = 1'b0;

    logic             pc_write, ifid_stall, ifid_flush, idex_bubble;
    logic             idex_hold, exmem_hold, memwb_bubble, timeout_err;
    logic [1:0]       state;
`ifdef HAZARD_PERF_EN
    logic [31:0]      perf_stall_cnt, perf_flush_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // Expected vector: pc_write, ifid_stall, ifid_flush, idex_bubble,
    // idex_hold, exmem_hold, memwb_bubble, state[1:0], timeout_err
    logic [9:0] exp_q[$];

    // Reference model: pipeline situation as plain integers.
    int          m_state = 0;
    bit          m_drop  = 0;
    int          m_wait  = 0;
    bit          m_err   = 0;
    int unsigned m_pstall = 0;
    int unsigned m_pflush = 0;

    hazard_ctrl #(
        .REG_W(REG_W), .CNT_W(CNT_W), .WAIT_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_rt(ex_rt),
        .ex_branch_taken(ex_branch_taken), .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .idex_hold(idex_hold), .exmem_hold(exmem_hold),
        .memwb_bubble(memwb_bubble), .state(state), .timeout_err(timeout_err)
`ifdef HAZARD_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Monitor: every falling edge with a pending expectation is one check.
    initial begin
        logic [9:0] e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {pc_write, ifid_stall, ifid_flush, idex_bubble, idex_hold,
                     exmem_hold, memwb_bubble, state, timeout_err};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL ctl @%0t: got %b required %b (pc,st,fl,bub,h,h,mb,state,to)",
                             $time, a, e);
                end
            end
        end
    end

    task automatic idle();
        ex_memread = 0; ex_rt = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
        ex_branch_taken = 0; imem_ready = 1; dmem_req = 0; dmem_ready = 0;
    endtask

    // One cycle: predict, enqueue, advance model, then move to next cycle.
    task automatic step();
        bit pc, stl, fl, bub, frz, lu, ne, nd;
        int ns, nw;
        if (!rst) begin
            exp_q.push_back('0);
            m_state = 0; m_drop = 0; m_wait = 0; m_err = 0;
            m_pstall = 0; m_pflush = 0;
        end else begin
            lu = ex_memread && ex_rt != 0 &&
                 (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
            pc = 0; stl = 0; fl = 0; bub = 0; frz = 0;
            ns = m_state; nd = m_drop; nw = m_wait; ne = m_err;
            if (m_state == 2 && m_wait == TO) ne = 1;
            if (m_state == 2 && !dmem_ready) begin
                frz = 1;
                nw = (m_wait < CNT_MAX) ? m_wait + 1 : m_wait;
            end else if (m_state != 2 && dmem_req && !dmem_ready) begin
                frz = 1; nw = 1; ns = 2;
            end else if (m_drop) begin
                fl = 1; nw = 0;
                if (imem_ready) begin ns = 0; nd = 0; end else ns = 3;
            end else begin
                nw = 0;
                if (ex_branch_taken) begin
                    pc = 1; fl = 1; bub = 1;
                    if (imem_ready) ns = 0; else begin ns = 3; nd = 1; end
                end else if (lu) begin
                    stl = 1; bub = 1;
                    ns = (m_state == 2) ? 0 : m_state;
                end else if (!imem_ready) begin
                    fl = 1; ns = 1;
                end else begin
                    pc = 1; ns = 0;
                end
            end
            exp_q.push_back({pc, stl | frz, fl, bub, frz, frz, frz, 2'(m_state), m_err});
            if (!pc) m_pstall++;
            if (fl)  m_pflush++;
            m_state = ns; m_drop = nd; m_wait = nw; m_err = ne;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 0; idle();
        step(); step();
        rst = 1;
    endtask

    initial begin
        @(posedge clk); #1;
        do_reset();
        step();

        // Load-use on rs, then a load to r0 which must not stall.
        ex_memread = 1; ex_rt = 5; id_rs = 5; step();
        idle(); step();
        ex_memread = 1; ex_rt = 0; id_rs = 0; step();
        idle(); step();
        // Load-use via rt.
        ex_memread = 1; ex_rt = 7; id_rt = 7; id_uses_rt = 1; step();
        idle(); step();
        // Branch with fetch ready.
        ex_branch_taken = 1; step();
        idle(); step();
`ifdef HAZARD_PERF_EN
        checks++;
        if (perf_stall_cnt !== 32'd2 || perf_flush_cnt !== 32'd1) begin
            errors++;
            $display("FAIL perf_directed: got stall=%0d flush=%0d required stall=2 flush=1",
                     perf_stall_cnt, perf_flush_cnt);
        end
`endif
        // Branch with fetch stalled for 3 cycles, then ready.
        ex_branch_taken = 1; imem_ready = 0; step();
        ex_branch_taken = 0; step(); step();
        imem_ready = 1; step();
        step();
        // Branch beats load-use.
        ex_branch_taken = 1; ex_memread = 1; ex_rt = 3; id_rs = 3; step();
        idle(); step();

        // Data wait of 4 cycles with a branch arriving mid-wait.
        do_reset();
        dmem_req = 1; dmem_ready = 0; step(); step();
        ex_branch_taken = 1; step(); step();
        dmem_ready = 1; step();
        idle(); step(); step();

        // Timeout: six waiting cycles, sticky after release, cleared by reset.
        do_reset();
        dmem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 6; i++) step();
        dmem_ready = 1; step();
        idle(); step(); step();
        do_reset();
        step();

        // Reset in the middle of a data wait.
        dmem_req = 1; dmem_ready = 0; step(); step();
        rst = 0; step();
        idle(); step();
        rst = 1; step(); step();

        // Randomised traffic.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            ex_memread      = ($urandom_range(0, 99) < 30);
            ex_rt           = REG_W'($urandom_range(0, 3));
            id_rs           = REG_W'($urandom_range(0, 3));
            id_rt           = REG_W'($urandom_range(0, 3));
            id_uses_rt      = $urandom_range(0, 1) == 1;
            ex_branch_taken = ($urandom_range(0, 99) < 15);
            imem_ready      = ($urandom_range(0, 99) < 70);
            dmem_req        = ($urandom_range(0, 99) < 25);
            dmem_ready      = ($urandom_range(0, 99) < 55);
            if ($urandom_range(0, 499) == 0) rst = 0;
            else rst = 1;
            step();
        end
        rst = 1; idle(); step();

`ifdef HAZARD_PERF_EN
        checks++;
        if (perf_stall_cnt !== m_pstall || perf_flush_cnt !== m_pflush) begin
            errors++;
            $display("FAIL perf_random: got stall=%0d flush=%0d required stall=%0d flush=%0d",
                     perf_stall_cnt, perf_flush_cnt, m_pstall, m_pflush);
        end
`endif
        @(negedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
